cluster_clock_divider_serv: RTL
===============================

Name: cluster_clock_divider_serv

Overview:
- Programmable integer clock divider for the serv cluster clock tree.
- Derives a slower clock from the cluster root clock. Sits beside the cluster clock inverter and gating cells, upstream of peripheral and low-speed domains.
- The divide ratio is reprogrammed at runtime through a valid/ack handshake.
- A new ratio is applied only at a period boundary, so clk_o never produces a runt pulse.
- Bypass and test mode pass the root clock straight through.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- DEFAULT_DIV, 1, ratio loaded at reset; 0 or 1 means bypass.

Ports:
- clk_i  input  1  root clock
- rst_ni  input  1  asynchronous active-low reset
- test_mode_i  input  1  1 = clk_o follows clk_i, ignoring the divider
- en_i  input  1  divider enable; 0 freezes the counter with the divided clock held low
- div_i  input  DIV_W  requested divide ratio
- div_valid_i  input  1  request to load div_i; held until div_ack_o
- div_ack_o  output  1  one-cycle pulse when the request is applied
- div_active_o  output  DIV_W  ratio currently in effect
- clk_o  output  1  divided clock

Behaviour:
- Clock and reset: single clock domain on clk_i; rst_ni asynchronous assert, synchronous deassert handled upstream.
- Reset values: cnt=0, div_q=DEFAULT_DIV, clk_div_q=0, div_ack_o=0, div_active_o=DEFAULT_DIV.
- clk_o at reset: equals clk_i if DEFAULT_DIV<=1, else 0.
- Ratio N = div_q.
  - N<=1: bypass, clk_o = clk_i.
  - N>=2: divided mode.
- Divided mode counter:
  - cnt counts 0..N-1 on each clk_i rising edge and wraps to 0.
  - clk_div_q is registered: 1 when cnt < floor(N/2), else 0.
  - Period is exactly N clk_i cycles. High time is floor(N/2) cycles, low time is ceil(N/2) cycles.
  - Example, N=3: high 1 cycle, low 2 cycles.
  - Boundary = cnt==N-1, the last low cycle.
- Handshake:
  - div_valid_i is sampled every cycle. The request is accepted only at a boundary, or at any cycle while in bypass or while en_i=0.
  - On acceptance: div_q<=div_i, cnt<=0, div_ack_o=1 for exactly one cycle, div_active_o updates in the same cycle as the ack.
  - The requester drops valid in the cycle after the ack.
  - valid still high after the ack counts as a new request. It is accepted at the next boundary with the same rules, and an equal value re-acks harmlessly.
- Mode switches:
  - Bypass to divided: taken on acceptance while clk_i is high. The mux switches only when both clk_i and clk_div_q are low, using the sub-module below. The first divided high phase starts at cnt=0.
  - Divided to bypass: switch at the boundary, with clk_div_q low.
- en_i=0:
  - cnt holds, clk_div_q is forced to 0 at the next edge, so clk_o stays low in divided mode.
  - Bypass mode is unaffected and clk_o = clk_i.
  - When en_i returns to 1, counting restarts from cnt=0.
- test_mode_i=1: clk_o = clk_i combinationally. The counter and handshake keep operating.
- Simultaneous events:
  - en_i fall together with an accepted request: the request is applied, cnt=0.
  - div_i=0 and div_i=1 are both bypass; div_active_o reports the written value.
- Reset mid-period: clk_o drops low (or follows clk_i if DEFAULT_DIV<=1) immediately. A pending request is discarded with no ack.

Decomposition:
- Package cluster_clock_serv_pkg: DIV_W default, typedef div_t (logic [DIV_W-1:0]), constant DIV_BYPASS_MAX=1.
- Sub-module cluster_clock_mux2_serv:
  - Glitch-free two-input clock mux built from cross-coupled negedge-synchronised select flops.
  - Selects clk_i or clk_div_q; instantiated once.
  - The test-mode override is applied after it.

Test Plan:
- Reset with DEFAULT_DIV=1, div_valid_i=0 -> clk_o tracks clk_i, div_active_o=1, div_ack_o never asserted.
- Request div_i=4 from bypass -> ack within 1 cycle. clk_o then has period 4 clk_i cycles, high 2 / low 2, with no pulse shorter than 1 clk_i period at the switch.
- At N=4, request div_i=3 with cnt=1 -> ack only at cnt==3. Subsequent periods are 3 cycles with high 1 / low 2. div_active_o changes from 4 to 3 in the ack cycle.
- At N=5, drop en_i for 7 cycles -> clk_o low throughout. After en_i=1, first high phase starts at cnt=0, lasting 2 cycles.
- At N=6, assert test_mode_i -> clk_o = clk_i. After deassert, the 6-cycle pattern resumes and a request issued during test mode is acked at a boundary.
- At N=8, assert rst_ni low at cnt=2 with div_valid_i=1 and div_i=2 -> clk_o low immediately (DEFAULT_DIV=8 build), no ack, div_active_o=8 after release.

Source files
------------

// File: rtl/cluster_clock_serv_pkg.sv
// Shared constants and types for the serv cluster clock divider.
package cluster_clock_serv_pkg;

  localparam int unsigned DIV_W_DEFAULT  = 8;
  localparam int unsigned DIV_BYPASS_MAX = 1;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/cluster_clock_mux2_serv.sv
// Glitch-free two-input clock mux: clk_a_i is the root clock, clk_b_i a clock
// launched from its rising edge, so both select flops can run on falling clk_a_i.
module cluster_clock_mux2_serv #(
  parameter bit SEL_B_RST = 1'b0
) (
  input  logic clk_a_i,
  input  logic rst_ni,
  input  logic clk_b_i,
  input  logic sel_b_i,
  output logic clk_o
);

  logic en_a_q, en_a_d;
  logic en_b_q, en_b_d;

  // Each enable may only rise once the other has fallen; en_b only moves while
  // clk_b_i is low so a divided high phase is never truncated.
  always_comb begin
    en_a_d = !sel_b_i && !en_b_q;
    en_b_d = en_b_q;
    if (!clk_b_i) en_b_d = sel_b_i && !en_a_q;
  end

  always_ff @(negedge clk_a_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_a_q <= !SEL_B_RST;
      en_b_q <= SEL_B_RST;
    end else begin
      en_a_q <= en_a_d;
      en_b_q <= en_b_d;
    end
  end

  assign clk_o = (clk_a_i && en_a_q) || (clk_b_i && en_b_q);

endmodule

// File: rtl/cluster_clock_divider_serv.sv
// Programmable integer clock divider with runtime ratio reload at period
// boundaries, bypass for ratios 0/1, and a test-mode pass-through.
module cluster_clock_divider_serv
  import cluster_clock_serv_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ack_o,
  output logic [DIV_W-1:0] div_active_o,
  output logic             clk_o
);

  localparam logic [DIV_W-1:0] DivRst    = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] BypassMax = DIV_W'(DIV_BYPASS_MAX);
  localparam bit               RstDivided = (DEFAULT_DIV > DIV_BYPASS_MAX);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_div_q, clk_div_d;
  logic             ack_q, ack_d;
  logic             en_q, en_d;
  logic             bypass, boundary, accept;
  logic             mux_clk;

  always_comb begin
    bypass   = (div_q <= BypassMax);
    boundary = (cnt_q == div_q - DIV_W'(1));
    accept   = div_valid_i && (bypass || !en_i || boundary);

    div_d = div_q;
    cnt_d = cnt_q;
    en_d  = en_i;
    ack_d = accept;

    // Counting restarts from zero on the first enabled edge after a freeze.
    if (accept) begin
      div_d = div_i;
      cnt_d = '0;
    end else if (en_i) begin
      if (bypass || !en_q || boundary) cnt_d = '0;
      else                             cnt_d = cnt_q + DIV_W'(1);
    end

    clk_div_d = en_i && (div_d > BypassMax) && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= DivRst;
      clk_div_q <= 1'b0;
      ack_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_div_q <= clk_div_d;
      ack_q     <= ack_d;
      en_q      <= en_d;
    end
  end

  cluster_clock_mux2_serv #(
    .SEL_B_RST (RstDivided)
  ) u_mux (
    .clk_a_i (clk_i),
    .rst_ni  (rst_ni),
    .clk_b_i (clk_div_q),
    .sel_b_i (div_q > BypassMax),
    .clk_o   (mux_clk)
  );

  assign clk_o        = test_mode_i ? clk_i : mux_clk;
  assign div_ack_o    = ack_q;
  assign div_active_o = div_q;

endmodule
